gpio_port: RTL and testbench



---
 rtl/gpio_port.sv | 119 +++++++++++
 tb/tb_gpio_port.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/gpio_port.sv
// Memory-mapped GPIO controller. Each pin has a direction bit, an output bit, an input
// synchroniser and rising/falling edge capture into a sticky status register that drives a level IRQ.
module gpio_port #(
  parameter int WIDTH       = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic             i_clk,
  input  logic             i_rstb,
  input  logic             i_clk_en,
  input  logic             i_cs,
  input  logic             i_we,
  input  logic [2:0]       i_addr,
  input  logic [WIDTH-1:0] i_wdata,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_rvalid,
  output logic             o_irq,
  inout  wire  [WIDTH-1:0] io_gpio
);

  typedef enum logic [2:0] {
    REG_OUT     = 3'd0,
    REG_DIR     = 3'd1,
    REG_IN      = 3'd2,
    REG_STAT    = 3'd3,
    REG_RISE_EN = 3'd4,
    REG_FALL_EN = 3'd5,
    REG_SET     = 3'd6,
    REG_CLR     = 3'd7
  } reg_e;

  reg_e             addr;
  logic             rd_en;
  logic             wr_en;
  logic [WIDTH-1:0] out_q;
  logic [WIDTH-1:0] dir_q;
  logic [WIDTH-1:0] rise_en_q;
  logic [WIDTH-1:0] fall_en_q;
  logic [WIDTH-1:0] stat_q;
  logic [WIDTH-1:0] prev_q;
  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] in_val;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic [WIDTH-1:0] w1c;
  logic [WIDTH-1:0] rd_mux;

  assign addr   = reg_e'(i_addr);
  assign rd_en  = i_clk_en & i_cs & ~i_we;
  assign wr_en  = i_clk_en & i_cs & i_we;
  assign in_val = sync_q[SYNC_STAGES-1];

  // Pins are driven straight from registers, so the bus never reaches a pad combinationally.
  for (genvar i = 0; i < WIDTH; i++) begin : g_pad
    assign io_gpio[i] = dir_q[i] ? out_q[i] : 1'bz;
  end

  // NOTE: every output of a combinational block gets a default first, otherwise a latch is inferred.
  always_comb begin
    rise   = in_val & ~prev_q & rise_en_q;
    fall   = ~in_val & prev_q & fall_en_q;
    w1c    = '0;
    rd_mux = '0;
    if (wr_en && addr == REG_STAT) w1c = i_wdata;
    case (addr)
      REG_OUT:     rd_mux = out_q;
      REG_DIR:     rd_mux = dir_q;
      REG_IN:      rd_mux = in_val;
      REG_STAT:    rd_mux = stat_q;
      REG_RISE_EN: rd_mux = rise_en_q;
      REG_FALL_EN: rd_mux = fall_en_q;
      default:     rd_mux = '0;
    endcase
  end

  // NOTE: the synchroniser is an array of flops, not RAM, so it is reset like any other state;
  // a stale pin value left in it would fake an edge right after reset.
  always_ff @(posedge i_clk or negedge i_rstb) begin
    if (!i_rstb) begin
      for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
    end else if (i_clk_en) begin
      sync_q[0] <= io_gpio;
      for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
  always_ff @(posedge i_clk or negedge i_rstb) begin
    if (!i_rstb) begin
      out_q     <= '0;
      dir_q     <= '0;
      rise_en_q <= '0;
      fall_en_q <= '0;
      stat_q    <= '0;
      prev_q    <= '0;
      o_rdata   <= '0;
      o_rvalid  <= 1'b0;
    end else if (i_clk_en) begin
      prev_q   <= in_val;
      // A new edge on a bit wins over a write-1-to-clear of the same bit.
      stat_q   <= (stat_q & ~w1c) | rise | fall;
      o_rvalid <= rd_en;
      if (rd_en) o_rdata <= rd_mux;
      if (wr_en) begin
        case (addr)
          REG_OUT:     out_q     <= i_wdata;
          REG_DIR:     dir_q     <= i_wdata;
          REG_RISE_EN: rise_en_q <= i_wdata;
          REG_FALL_EN: fall_en_q <= i_wdata;
          REG_SET:     out_q     <= out_q | i_wdata;
          REG_CLR:     out_q     <= out_q & ~i_wdata;
          default:     ;
        endcase
      end
    end
  end

  assign o_irq = |stat_q;

endmodule

// File: tb/tb_gpio_port.sv
// Bench for gpio_port: constant register-map vectors, timed edge/enable/reset sequences,
// then random bus and pin traffic compared against a history-queue reference model.
module tb_gpio_port;

  localparam int W = 32;
  localparam int S = 2;

  localparam logic [2:0] A_OUT = 3'd0, A_DIR = 3'd1, A_IN = 3'd2, A_STAT = 3'd3,
                         A_RISE = 3'd4, A_FALL = 3'd5, A_SET = 3'd6, A_CLR = 3'd7;

  logic         clk = 1'b0;
  logic         rstb;
  logic         clk_en, cs, we;
  logic [2:0]   addr;
  logic [W-1:0] wdata, rdata;
  logic         rvalid, irq;
  wire  [W-1:0] gpio;
  logic [W-1:0] tb_oe, tb_drv;

  int checks = 0;
  int failures = 0;

  for (genvar i = 0; i < W; i++) begin : g_drv
    assign gpio[i] = tb_oe[i] ? tb_drv[i] : 1'bz;
  end

  always #5 clk = ~clk;

  gpio_port #(.WIDTH(W), .SYNC_STAGES(S)) dut (
    .i_clk(clk), .i_rstb(rstb), .i_clk_en(clk_en), .i_cs(cs), .i_we(we),
    .i_addr(addr), .i_wdata(wdata), .o_rdata(rdata), .o_rvalid(rvalid),
    .o_irq(irq), .io_gpio(gpio)
  );

  // Reference model: register values plus a queue of pin samples, newest first.
  logic [W-1:0] m_out, m_dir, m_ren, m_fen, m_stat, m_rdata, m_prev;
  logic         m_rvalid;
  logic [W-1:0] m_hist[$];

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    {m_out, m_dir, m_ren, m_fen, m_stat, m_rdata, m_prev} = '0;
    m_rvalid = 1'b0;
    m_hist.delete();
    for (int k = 0; k < S; k++) m_hist.push_back('0);
  endtask

  function automatic logic [W-1:0] pins_expected();
    return (m_dir & m_out) | (~m_dir & tb_drv);
  endfunction

  task automatic model_edge(input bit en, input bit c, input bit w,
                            input logic [2:0] a, input logic [W-1:0] d);
    logic [W-1:0] pin, cur_in, edges, clr, val;
    if (!en) return;
    pin    = pins_expected();
    cur_in = m_hist[S-1];
    edges  = (cur_in & ~m_prev & m_ren) | (~cur_in & m_prev & m_fen);
    clr    = (c && w && a == A_STAT) ? d : '0;
    case (a)
      A_OUT:   val = m_out;
      A_DIR:   val = m_dir;
      A_IN:    val = cur_in;
      A_STAT:  val = m_stat;
      A_RISE:  val = m_ren;
      A_FALL:  val = m_fen;
      default: val = '0;
    endcase
    m_rvalid = c && !w;
    if (c && !w) m_rdata = val;
    if (c && w) begin
      case (a)
        A_OUT:  m_out = d;
        A_DIR:  m_dir = d;
        A_RISE: m_ren = d;
        A_FALL: m_fen = d;
        A_SET:  m_out = m_out | d;
        A_CLR:  m_out = m_out & ~d;
        default: ;
      endcase
    end
    m_stat = (m_stat & ~clr) | edges;
    m_prev = cur_in;
    m_hist.push_front(pin);
    void'(m_hist.pop_back());
  endtask

  // One clock cycle: drive inputs while clk is low, let the edge pass, compare at the falling edge.
  task automatic step(input bit en, input bit c, input bit w,
                      input logic [2:0] a, input logic [W-1:0] d);
    clk_en = en; cs = c; we = w; addr = a; wdata = d;
    model_edge(en, c, w, a, d);
    @(posedge clk);
    #1 tb_oe = ~m_dir;
    @(negedge clk);
    check("model_rdata", rdata, m_rdata);
    check("model_rvalid", W'(rvalid), W'(m_rvalid));
    check("model_irq", W'(irq), W'(|m_stat));
    check("model_pins", gpio, pins_expected());
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1, 0, 0, 3'd0, '0);
  endtask

  task automatic wr(input logic [2:0] a, input logic [W-1:0] d);
    step(1, 1, 1, a, d);
  endtask

  task automatic rd(input logic [2:0] a, input logic [W-1:0] exp);
    step(1, 1, 0, a, '0);
    check("read_data", rdata, exp);
    check("read_valid", W'(rvalid), W'(1));
  endtask

  typedef struct {
    bit           we;
    logic [2:0]   addr;
    logic [W-1:0] wdata;
    logic [W-1:0] exp;
    bit           pin_chk;
    logic [W-1:0] exp_pins;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input bit w, input logic [2:0] a, input logic [W-1:0] d,
                     input logic [W-1:0] exp, input bit pc, input logic [W-1:0] ep);
    vec_t v;
    v.we = w; v.addr = a; v.wdata = d; v.exp = exp; v.pin_chk = pc; v.exp_pins = ep;
    tbl.push_back(v);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int r = 0; r < 8; r++) add(0, 3'(r), '0, '0, 0, '0);
    add(1, A_DIR,  32'h0000FFFF, '0, 0, '0);
    add(1, A_OUT,  32'h12345678, '0, 0, '0);
    add(0, A_OUT,  '0, 32'h12345678, 1, 32'h00005678);
    add(0, A_DIR,  '0, 32'h0000FFFF, 0, '0);
    add(1, A_SET,  32'h00010001, '0, 0, '0);
    add(1, A_CLR,  32'h00000008, '0, 0, '0);
    add(0, A_OUT,  '0, 32'h12355671, 1, 32'h00005671);
    add(0, A_SET,  '0, '0, 0, '0);
    add(0, A_CLR,  '0, '0, 0, '0);
    add(1, A_IN,   32'hFFFFFFFF, '0, 0, '0);
    add(1, A_RISE, 32'hA5A5A5A5, '0, 0, '0);
    add(1, A_FALL, 32'h5A5A5A5A, '0, 0, '0);
    add(0, A_RISE, '0, 32'hA5A5A5A5, 0, '0);
    add(0, A_FALL, '0, 32'h5A5A5A5A, 0, '0);
    add(1, A_RISE, '0, '0, 0, '0);
    add(1, A_FALL, '0, '0, 0, '0);
    add(0, A_IN,   '0, 32'h00005671, 0, '0);
    add(0, A_STAT, '0, '0, 1, 32'h00005671);

    rstb = 1'b0; clk_en = 1'b0; cs = 1'b0; we = 1'b0; addr = '0; wdata = '0;
    tb_oe = '1; tb_drv = '0;
    model_reset();
    repeat (2) @(negedge clk);
    check("reset_rvalid", W'(rvalid), '0);
    check("reset_irq", W'(irq), '0);
    check("reset_rdata", rdata, '0);
    rstb = 1'b1;

    // Register map against fixed expectations.
    foreach (tbl[i]) begin
      step(1, 1, tbl[i].we, tbl[i].addr, tbl[i].wdata);
      if (!tbl[i].we) begin
        check("tbl_rdata", rdata, tbl[i].exp);
        check("tbl_rvalid", W'(rvalid), W'(1));
      end else begin
        check("tbl_no_rvalid", W'(rvalid), '0);
      end
      if (tbl[i].pin_chk) check("tbl_pins", gpio, tbl[i].exp_pins);
    end

    // Rising edge on pin 0: sampled at the first edge, STAT set on the third.
    wr(A_DIR, '0); wr(A_OUT, '0); tb_drv = '0; idle(3);
    wr(A_STAT, '1); wr(A_RISE, 32'h1); idle(1);
    tb_drv[0] = 1'b1;
    step(1, 0, 0, 3'd0, '0); check("rise_irq_e0", W'(irq), '0);
    step(1, 0, 0, 3'd0, '0); check("rise_irq_e1", W'(irq), '0);
    step(1, 0, 0, 3'd0, '0); check("rise_irq_e2", W'(irq), W'(1));
    rd(A_STAT, 32'h1);
    wr(A_STAT, 32'h1); check("w1c_irq", W'(irq), '0);
    rd(A_STAT, '0);

    // Falling edge on pin 31, then a clear colliding with a fresh falling edge.
    wr(A_RISE, '0); wr(A_FALL, 32'h80000000); tb_drv[31] = 1'b1; idle(4);
    wr(A_STAT, '1); rd(A_STAT, '0);
    tb_drv[31] = 1'b0;
    step(1, 0, 0, 3'd0, '0); check("fall_irq_e0", W'(irq), '0);
    step(1, 0, 0, 3'd0, '0); check("fall_irq_e1", W'(irq), '0);
    step(1, 0, 0, 3'd0, '0); check("fall_irq_e2", W'(irq), W'(1));
    rd(A_STAT, 32'h80000000);
    tb_drv[31] = 1'b1; idle(1);
    tb_drv[31] = 1'b0; idle(2);
    wr(A_STAT, 32'h80000000); check("collide_irq", W'(irq), W'(1));
    rd(A_STAT, 32'h80000000);
    wr(A_STAT, 32'h80000000); rd(A_STAT, '0);

    // Clock enable low: read and pin edge are frozen, then resume.
    wr(A_FALL, '0); wr(A_RISE, 32'h1); tb_drv[0] = 1'b0; idle(4);
    wr(A_STAT, '1); idle(1);
    tb_drv[0] = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step(0, 1, 0, A_STAT, '0);
      check("cke_rvalid", W'(rvalid), '0);
      check("cke_irq", W'(irq), '0);
    end
    step(1, 0, 0, 3'd0, '0); check("cke_irq_e1", W'(irq), '0);
    step(1, 0, 0, 3'd0, '0); check("cke_irq_e2", W'(irq), '0);
    step(1, 0, 0, 3'd0, '0); check("cke_irq_e3", W'(irq), W'(1));

    // Self-triggered edges on output pins, then asynchronous reset mid-read.
    wr(A_RISE, 32'hF); tb_drv = '0; wr(A_OUT, '0); wr(A_DIR, 32'hFF); idle(4);
    wr(A_STAT, '1); wr(A_OUT, 32'hFF); idle(4);
    rd(A_STAT, 32'hF);
    check("pre_reset_pins", gpio, 32'h000000FF);
    step(1, 1, 0, A_DIR, '0);
    check("pre_reset_rvalid", W'(rvalid), W'(1));
    rstb = 1'b0; tb_oe = '1; tb_drv = '0; model_reset();
    #1;
    check("async_rvalid", W'(rvalid), '0);
    check("async_irq", W'(irq), '0);
    check("async_pins", gpio, '0);
    @(negedge clk); rstb = 1'b1;
    rd(A_STAT, '0); rd(A_DIR, '0); rd(A_OUT, '0);

    // Random bus traffic and sparse pin toggles against the model.
    for (int n = 0; n < 600; n++) begin
      tb_drv = tb_drv ^ ($urandom & $urandom & $urandom);
      step($urandom_range(0, 9) != 0, $urandom_range(0, 2) != 0, $urandom_range(0, 1) == 1,
           3'($urandom_range(0, 7)), $urandom);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
